// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//   Serial TDM frame demultiplexer. A frame is a 4-bit sync pattern followed
//   by a W-bit channel-A word and a W-bit channel-B word, every field MSB
//   first, with frames sent back to back. The block hunts for the sync
//   pattern, splits the two channel words out of the serial stream, and then
//   re-checks the sync field of each following frame to keep alignment.
//
// Parameters
//   W     : channel word width in bits (W >= 2)
//   SYNC  : 4-bit frame sync pattern, MSB received first
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   synchronous active-high reset
//   din       in   serial TDM line
//   en        in   bit enable; one bit of din is accepted per edge with en=1
//   a_data    out  [W-1:0] last complete channel-A word
//   b_data    out  [W-1:0] last complete channel-B word
//   a_valid   out  one-cycle pulse, a_data updated this cycle
//   b_valid   out  one-cycle pulse, b_data updated this cycle
//   locked    out  frame alignment confirmed
//   sync_err  out  one-cycle pulse, expected sync pattern not received
// ---------------------------------------------------------------------------
module tdm_demux #(
    parameter int         W    = 8,
    parameter logic [3:0] SYNC = 4'b1011
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         din,
    input  logic         en,
    output logic [W-1:0] a_data,
    output logic [W-1:0] b_data,
    output logic         a_valid,
    output logic         b_valid,
    output logic         locked,
    output logic         sync_err
);

    // The counter has to index both a W-bit word and the 4-bit sync field.
    localparam int MAXN = (W > 4) ? W : 4;
    localparam int CW   = $clog2(MAXN);

    localparam logic [CW-1:0] LAST_WORD = CW'(W - 1);
    localparam logic [CW-1:0] LAST_SYNC = CW'(3);
    localparam logic [3:0]    SYNC_PAT  = SYNC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        RECV_A = 2'd1,
        RECV_B = 2'd2,
        CHECK  = 2'd3
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [3:0]     hist;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;

    // Sync bit expected at position k of the CHECK field is SYNC[3-k];
    // for a 2-bit k, 3-k is simply ~k.
    logic           exp_sync_bit;
    logic [3:0]     hunt_window;

    always_comb begin
        exp_sync_bit = SYNC_PAT[~cnt[1:0]];
        hunt_window  = {hist[2:0], din};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HUNT;
            cnt      <= '0;
            hist     <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            a_data   <= '0;
            b_data   <= '0;
            a_valid  <= 1'b0;
            b_valid  <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            // Pulses are single-cycle no matter what en does next.
            a_valid  <= 1'b0;
            b_valid  <= 1'b0;
            sync_err <= 1'b0;

            if (en) begin
                case (state)
                    HUNT: begin
                        hist <= hunt_window;
                        // A match on data bits is accepted here too; a false
                        // lock is caught later by the CHECK field.
                        if (hunt_window == SYNC_PAT) begin
                            state <= RECV_A;
                            cnt   <= '0;
                        end
                    end

                    RECV_A: begin
                        a_sh <= {a_sh[W-2:0], din};
                        if (cnt == LAST_WORD) begin
                            a_data  <= {a_sh[W-2:0], din};
                            a_valid <= 1'b1;
                            state   <= RECV_B;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    RECV_B: begin
                        b_sh <= {b_sh[W-2:0], din};
                        if (cnt == LAST_WORD) begin
                            b_data  <= {b_sh[W-2:0], din};
                            b_valid <= 1'b1;
                            locked  <= 1'b1;
                            state   <= CHECK;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    CHECK: begin
                        if (din != exp_sync_bit) begin
                            // The offending bit is dropped rather than fed
                            // into the new search, so history restarts empty.
                            state    <= HUNT;
                            hist     <= '0;
                            cnt      <= '0;
                            locked   <= 1'b0;
                            sync_err <= 1'b1;
                        end else if (cnt == LAST_SYNC) begin
                            state <= RECV_A;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    default: begin
                        state <= HUNT;
                        cnt   <= '0;
                        hist  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       en;
    logic [7:0] a_data;
    logic [7:0] b_data;
    logic       a_valid;
    logic       b_valid;
    logic       locked;
    logic       sync_err;

    int checks   = 0;
    int failures = 0;

    // pulse monitor
    int   a_cnt = 0, b_cnt = 0, e_cnt = 0, wide_cnt = 0;
    logic a_prev = 1'b0, b_prev = 1'b0, e_prev = 1'b0;

    tdm_demux #(.W(8), .SYNC(4'b1011)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .en       (en),
        .a_data   (a_data),
        .b_data   (b_data),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .locked   (locked),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_valid) a_cnt <= a_cnt + 1;
        if (b_valid) b_cnt <= b_cnt + 1;
        if (sync_err) e_cnt <= e_cnt + 1;
        if ((a_valid && a_prev) || (b_valid && b_prev) || (sync_err && e_prev))
            wide_cnt <= wide_cnt + 1;
        a_prev <= a_valid;
        b_prev <= b_valid;
        e_prev <= sync_err;
    end

    typedef struct {
        logic [3:0] sync;
        logic [7:0] a;
        logic [7:0] b;
        int         gap;
        logic       lock_before;
    } fvec_t;

    fvec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        en  = 1'b1;
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            en  = 1'b0;
            din = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame; en held low for 'gap' cycles after every bit.
    // Checks one-clock latency on the last bit of each word.
    task automatic send_frame(input logic [3:0] sync, input logic [7:0] a,
                              input logic [7:0] b, input int gap, input logic lock_before);
        for (int i = 3; i >= 0; i--) begin
            send_bit(sync[i]);
            idle(gap);
        end
        for (int i = 7; i >= 0; i--) begin
            send_bit(a[i]);
            if (i == 0) begin
                chk("a_valid_latency", 32'(a_valid), 32'd1);
                chk("a_data", 32'(a_data), 32'(a));
                chk("locked_after_a", 32'(locked), 32'(lock_before));
            end
            idle(gap);
        end
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i == 0) begin
                chk("b_valid_latency", 32'(b_valid), 32'd1);
                chk("b_data", 32'(b_data), 32'(b));
                chk("locked_with_b", 32'(locked), 32'd1);
            end
            idle(gap);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b1;
        din   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        en    = 1'b0;
    endtask

    int a0, b0, e0, w0;

    task automatic snap();
        a0 = a_cnt; b0 = b_cnt; e0 = e_cnt; w0 = wide_cnt;
    endtask

    task automatic chk_frame_pulses(input int na, input int nb, input int ne);
        chk("a_pulse_count", 32'(a_cnt - a0), 32'(na));
        chk("b_pulse_count", 32'(b_cnt - b0), 32'(nb));
        chk("sync_err_count", 32'(e_cnt - e0), 32'(ne));
        chk("pulse_width", 32'(wide_cnt - w0), 32'd0);
    endtask

    initial begin
        tbl[0] = '{sync: 4'b1011, a: 8'hA5, b: 8'h3C, gap: 0, lock_before: 1'b0};
        tbl[1] = '{sync: 4'b1011, a: 8'h01, b: 8'h80, gap: 0, lock_before: 1'b1};
        tbl[2] = '{sync: 4'b1011, a: 8'hFF, b: 8'h00, gap: 0, lock_before: 1'b1};
        tbl[3] = '{sync: 4'b1011, a: 8'h96, b: 8'h69, gap: 2, lock_before: 1'b1};

        din = 1'b0;
        do_reset();

        // reset state
        chk("rst_a_data", 32'(a_data), 32'd0);
        chk("rst_b_data", 32'(b_data), 32'd0);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);

        // frame, back-to-back and enable-gap frames
        for (int t = 0; t < 4; t++) begin
            snap();
            send_frame(tbl[t].sync, tbl[t].a, tbl[t].b, tbl[t].gap, tbl[t].lock_before);
            idle(1);
            chk_frame_pulses(1, 1, 0);
            chk("locked_end", 32'(locked), 32'd1);
        end

        // sync corruption: 1001 mismatches SYNC on the third bit
        snap();
        send_bit(1'b1);
        send_bit(1'b0);
        chk("no_err_bit2", 32'(sync_err), 32'd0);
        chk("locked_bit2", 32'(locked), 32'd1);
        send_bit(1'b0);
        chk("err_bit3", 32'(sync_err), 32'd1);
        chk("unlock_bit3", 32'(locked), 32'd0);
        chk("hold_a_data", 32'(a_data), 32'h96);
        send_bit(1'b1);
        chk("err_one_cycle", 32'(sync_err), 32'd0);
        send_frame(4'b1011, 8'h5A, 8'hC3, 0, 1'b0);
        idle(1);
        chk_frame_pulses(1, 1, 1);

        // mid-frame reset after 3 A bits
        do_reset();
        snap();
        for (int i = 3; i >= 0; i--) send_bit(tbl[0].sync[i]);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset = 1'b1;
        en    = 1'b1;
        din   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        en    = 1'b0;
        chk("mrst_a_data", 32'(a_data), 32'd0);
        chk("mrst_b_data", 32'(b_data), 32'd0);
        chk("mrst_a_valid", 32'(a_valid), 32'd0);
        chk("mrst_b_valid", 32'(b_valid), 32'd0);
        chk("mrst_locked", 32'(locked), 32'd0);
        chk("mrst_sync_err", 32'(sync_err), 32'd0);
        idle(1);
        chk("mrst_no_a_pulse", 32'(a_cnt - a0), 32'd0);
        send_frame(4'b1011, 8'h3C, 8'hA5, 0, 1'b0);
        idle(1);
        chk_frame_pulses(1, 1, 0);

        // preamble 0111 before the real sync
        do_reset();
        snap();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("pre_locked", 32'(locked), 32'd0);
        send_frame(4'b1011, 8'hC6, 8'h2D, 0, 1'b0);
        idle(1);
        chk_frame_pulses(1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
